// File: rtl/fifo_frame_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_frame_packer_pkg
// Description : Shared types and parameter legal ranges for the frame packer.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_frame_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int c_PACK_MIN  = 1;
    localparam int c_PACK_MAX  = 4;
    localparam int c_LEN_W_MIN = 1;
    localparam int c_LEN_W_MAX = 32;

    // Counter width that still works when the count range collapses to one value.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_frame_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_frame_packer_if
// Description : Control, FIFO read-port and packed output stream bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_frame_packer_if #(
    parameter int DATA_W = 11,
    parameter int PACK   = 2,
    parameter int LEN_W  = 16
) ();

    logic                     start;
    logic [LEN_W-1:0]         frame_len;
    logic                     abort;
    logic [DATA_W-1:0]        fifo_rd_data;
    logic                     fifo_rd_vld;
    logic                     fifo_rd_en;
    logic [DATA_W*PACK-1:0]   m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     m_last;
    logic                     busy;
    logic                     done;

    modport slave (
        input  start, frame_len, abort, fifo_rd_data, fifo_rd_vld, m_ready,
        output fifo_rd_en, m_data, m_valid, m_last, busy, done
    );

    modport master (
        output start, frame_len, abort, fifo_rd_data, fifo_rd_vld, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_last, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/fifo_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_frame_packer
// Description : Pops frame_len*PACK samples from a show-ahead FIFO and packs
//               each PACK-sample group into one valid/ready output word.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_frame_packer
    import fifo_frame_packer_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int PACK   = 2,
    parameter int LEN_W  = 16
) (
    input  wire logic          rd_clk,
    input  wire logic          rd_rst,
    fifo_frame_packer_if.slave bus
);

    localparam int                 c_SMP_W    = cnt_width(PACK);
    localparam logic [c_SMP_W-1:0] c_SMP_LAST = c_SMP_W'(PACK - 1);

    typedef logic [PACK-1:0][DATA_W-1:0] acc_t;

    generate
        if (PACK < c_PACK_MIN || PACK > c_PACK_MAX) begin : g_bad_pack
            $error("fifo_frame_packer: PACK out of legal range");
        end
        if (LEN_W < c_LEN_W_MIN || LEN_W > c_LEN_W_MAX) begin : g_bad_len_w
            $error("fifo_frame_packer: LEN_W out of legal range");
        end
    endgenerate

    state_t                 state_q, state_d;
    logic [c_SMP_W-1:0]     smp_cnt_q, smp_cnt_d;
    logic [LEN_W-1:0]       words_left_q, words_left_d;
    acc_t                   acc_q, acc_d;
    logic [DATA_W*PACK-1:0] m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_last_q, m_last_d;
    logic                   done_q, done_d;

    logic w_rd_en;
    logic w_pop;
    logic w_word;
    logic w_accept;
    logic w_final;

    // A word-completing pop needs the output register free or draining this cycle.
    assign w_rd_en  = (state_q == ST_RUN) & ~bus.abort &
                      ((smp_cnt_q != c_SMP_LAST) | ~m_valid_q | bus.m_ready);
    assign w_pop    = w_rd_en & bus.fifo_rd_vld;
    assign w_word   = w_pop & (smp_cnt_q == c_SMP_LAST);
    assign w_accept = m_valid_q & bus.m_ready;
    assign w_final  = (words_left_q == LEN_W'(1));

    always_comb begin
        state_d      = state_q;
        smp_cnt_d    = smp_cnt_q;
        words_left_d = words_left_q;
        acc_d        = acc_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.frame_len != '0)) begin
                    state_d      = ST_RUN;
                    words_left_d = bus.frame_len;
                    smp_cnt_d    = '0;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    m_valid_d = 1'b0;
                    smp_cnt_d = '0;
                end else begin
                    if (w_accept) begin
                        m_valid_d = 1'b0;
                    end
                    if (w_pop) begin
                        for (int i = 0; i < PACK; i++) begin
                            if (smp_cnt_q == c_SMP_W'(i)) begin
                                acc_d[i] = bus.fifo_rd_data;
                            end
                        end
                        smp_cnt_d = (smp_cnt_q == c_SMP_LAST) ? '0 : smp_cnt_q + c_SMP_W'(1);
                    end
                    // acc_d already holds the current sample in the top slot here.
                    if (w_word) begin
                        m_data_d     = acc_d;
                        m_valid_d    = 1'b1;
                        m_last_d     = w_final;
                        words_left_d = words_left_q - LEN_W'(1);
                        if (w_final) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (bus.abort) begin
                    state_d   = ST_IDLE;
                    m_valid_d = 1'b0;
                    smp_cnt_d = '0;
                end else if (w_accept) begin
                    m_valid_d = 1'b0;
                    if (m_last_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q      <= ST_IDLE;
            smp_cnt_q    <= '0;
            words_left_q <= '0;
            acc_q        <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            smp_cnt_q    <= smp_cnt_d;
            words_left_q <= words_left_d;
            acc_q        <= acc_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            done_q       <= done_d;
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_data     = m_data_q;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_last     = m_last_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;

endmodule
`default_nettype wire
